// File: rtl/memaccess.sv
// Memory-access stage: registers execute results and issues one req/ack data-memory access per load/store.
// Latency: ALU ops pass in 1 cycle; memory ops take REQ (>=1 cycle, until ack) plus 1 RESP cycle.
// Backpressure: o_stall is held high for every REQ cycle and the stage captures nothing while it is high.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word ops skip the bus and flag o_misaligned).
module memaccess #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int INST_SIZE = 32,
    parameter int NUM_REGS  = 32
) (
    input  logic                        i_aclk,
    input  logic                        i_areset_n,
    input  logic                        i_cu_memread,
    input  logic                        i_cu_memwrite,
    input  logic [1:0]                  i_cu_memsize,
    input  logic                        i_cu_memunsigned,
    input  logic                        i_cu_regwrite,
    input  logic [1:0]                  i_cu_memtoreg,
    input  logic [$clog2(NUM_REGS)-1:0] i_rdest,
    input  logic [INST_SIZE-1:0]        i_pcplus4,
    input  logic [DATA_SIZE-1:0]        i_exe_data,
    input  logic [DATA_SIZE-1:0]        i_store_data,
    output logic                        o_stall,
    output logic                        o_dmem_req,
    output logic                        o_dmem_we,
    output logic [ADDR_SIZE-1:0]        o_dmem_addr,
    output logic [3:0]                  o_dmem_be,
    output logic [DATA_SIZE-1:0]        o_dmem_wdata,
    input  logic                        i_dmem_ack,
    input  logic [DATA_SIZE-1:0]        i_dmem_rdata,
    output logic                        o_cu_regwrite,
    output logic [1:0]                  o_cu_memtoreg,
    output logic [$clog2(NUM_REGS)-1:0] o_rdest,
    output logic [INST_SIZE-1:0]        o_pcplus4,
    output logic [DATA_SIZE-1:0]        o_exe_data,
    output logic [DATA_SIZE-1:0]        o_mem_data,
    output logic                        o_misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                        state_q, state_d;
    logic                          regwrite_q, memread_q, memwrite_q, mis_q;
    logic [1:0]                    memsize_q, memtoreg_q;
    logic                          memunsigned_q;
    logic [$clog2(NUM_REGS)-1:0]   rdest_q;
    logic [INST_SIZE-1:0]          pcplus4_q;
    logic [DATA_SIZE-1:0]          exe_data_q, store_data_q, rdata_q;
    logic                          capture;
    logic                          mis_in;
    logic [1:0]                    lane;
    logic [7:0]                    ld_byte;
    logic [15:0]                   ld_half;
    logic [DATA_SIZE-1:0]          ld_ext;

    assign capture = (state_q != REQ);
    assign lane    = exe_data_q[1:0];

`ifdef MISALIGN_TRAP_EN
    // Half needs addr[0]=0, word (size 1x) needs addr[1:0]=0.
    assign mis_in = (i_cu_memread | i_cu_memwrite) &
                    (((i_cu_memsize == 2'b01) & i_exe_data[0]) |
                     (i_cu_memsize[1] & (i_exe_data[1:0] != 2'b00)));
`else
    assign mis_in = 1'b0;
`endif

    // FSM state register; control bits of the stage register share the async reset.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q    <= IDLE;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                regwrite_q <= i_cu_regwrite;
                memread_q  <= i_cu_memread;
                memwrite_q <= i_cu_memwrite;
                mis_q      <= mis_in;
            end
        end
    end

    // Data/address stage registers are not reset; they only load on capture.
    always_ff @(posedge i_aclk) begin
        if (capture) begin
            memsize_q     <= i_cu_memsize;
            memunsigned_q <= i_cu_memunsigned;
            memtoreg_q    <= i_cu_memtoreg;
            rdest_q       <= i_rdest;
            pcplus4_q     <= i_pcplus4;
            exe_data_q    <= i_exe_data;
            store_data_q  <= i_store_data;
        end
    end

    // Next state: capture decides REQ/IDLE (or RESP for a trapped op); REQ waits for ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ: begin
                if (i_dmem_ack) state_d = RESP;
            end
            default: begin
                if (mis_in)                              state_d = RESP;
                else if (i_cu_memread | i_cu_memwrite)   state_d = REQ;
                else                                     state_d = IDLE;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension from the live bus data.
    always_comb begin
        ld_byte = i_dmem_rdata[8*lane +: 8];
        ld_half = i_dmem_rdata[16*lane[1] +: 16];
        ld_ext  = i_dmem_rdata;
        case (memsize_q)
            2'b00:   ld_ext = {{(DATA_SIZE-8){ld_byte[7] & ~memunsigned_q}}, ld_byte};
            2'b01:   ld_ext = {{(DATA_SIZE-16){ld_half[15] & ~memunsigned_q}}, ld_half};
            default: ld_ext = i_dmem_rdata;
        endcase
    end

    // Aligned load result is captured on the ack cycle and held for writeback.
    always_ff @(posedge i_aclk) begin
        if ((state_q == REQ) && i_dmem_ack && memread_q) rdata_q <= ld_ext;
    end

    // Store byte enables and lane-replicated write data; reads enable all lanes.
    always_comb begin
        o_dmem_be    = 4'b1111;
        o_dmem_wdata = store_data_q;
        case (memsize_q)
            2'b00: begin
                o_dmem_wdata = {4{store_data_q[7:0]}};
                if (memwrite_q) o_dmem_be = 4'b0001 << lane;
            end
            2'b01: begin
                o_dmem_wdata = {2{store_data_q[15:0]}};
                if (memwrite_q) o_dmem_be = 4'b0011 << {lane[1], 1'b0};
            end
            default: begin
                o_dmem_wdata = store_data_q;
            end
        endcase
    end

    // Bus and writeback outputs; a REQ or trapped RESP cycle presents a bubble.
    always_comb begin
        o_stall       = (state_q == REQ);
        o_dmem_req    = (state_q == REQ);
        o_cu_regwrite = (state_q != REQ) & regwrite_q & ~mis_q;
`ifdef MISALIGN_TRAP_EN
        o_misaligned  = (state_q == RESP) & mis_q;
`else
        o_misaligned  = 1'b0;
`endif
    end

    assign o_dmem_we     = memwrite_q;
    assign o_dmem_addr   = {exe_data_q[ADDR_SIZE-1:2], 2'b00};
    assign o_cu_memtoreg = memtoreg_q;
    assign o_rdest       = rdest_q;
    assign o_pcplus4     = pcplus4_q;
    assign o_exe_data    = exe_data_q;
    assign o_mem_data    = rdata_q;

endmodule

// File: tb/tb_memaccess.sv
// Directed-vector bench for memaccess: table of loads/stores plus hand sequences
// for stall length, back-to-back issue, async reset mid-request and misalignment.
module tb_memaccess;

    logic        aclk = 1'b0;
    logic        areset_n = 1'b0;
    logic        memread = 0, memwrite = 0, memunsigned = 0, regwrite = 0;
    logic [1:0]  memsize = 0, memtoreg = 0;
    logic [4:0]  rdest = 0;
    logic [31:0] pcplus4 = 0, exe_data = 0, store_data = 0;
    logic        stall, dmem_req, dmem_we, dmem_ack = 0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
    logic [3:0]  dmem_be;
    logic        o_regwrite, misaligned;
    logic [1:0]  o_memtoreg;
    logic [4:0]  o_rdest;
    logic [31:0] o_pcplus4, o_exe_data, o_mem_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    memaccess dut (
        .i_aclk(aclk), .i_areset_n(areset_n),
        .i_cu_memread(memread), .i_cu_memwrite(memwrite), .i_cu_memsize(memsize),
        .i_cu_memunsigned(memunsigned), .i_cu_regwrite(regwrite), .i_cu_memtoreg(memtoreg),
        .i_rdest(rdest), .i_pcplus4(pcplus4), .i_exe_data(exe_data), .i_store_data(store_data),
        .o_stall(stall), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
        .o_dmem_be(dmem_be), .o_dmem_wdata(dmem_wdata), .i_dmem_ack(dmem_ack),
        .i_dmem_rdata(dmem_rdata), .o_cu_regwrite(o_regwrite), .o_cu_memtoreg(o_memtoreg),
        .o_rdest(o_rdest), .o_pcplus4(o_pcplus4), .o_exe_data(o_exe_data),
        .o_mem_data(o_mem_data), .o_misaligned(misaligned)
    );

    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          reqcyc;
        logic [31:0] exp_md;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic rw, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [31:0] sd);
        memread = ld; memwrite = st; memsize = sz; memunsigned = uns; regwrite = rw;
        memtoreg = ld ? 2'b01 : 2'b00; rdest = rd; pcplus4 = addr + 32'h1000;
        exe_data = addr; store_data = sd;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        drive(v.ld, v.st, v.size, v.uns, v.ld, idx[4:0], v.addr, v.sd);
        dmem_ack = 1'b0;
        step();
        for (int k = 0; k < v.reqcyc; k++) begin
            chk({v.name, " req"},   {31'b0, dmem_req}, 32'd1);
            chk({v.name, " stall"}, {31'b0, stall}, 32'd1);
            chk({v.name, " rw bubble"}, {31'b0, o_regwrite}, 32'd0);
            chk({v.name, " addr"},  dmem_addr, v.addr & 32'hFFFF_FFFC);
            chk({v.name, " we"},    {31'b0, dmem_we}, {31'b0, v.st});
            chk({v.name, " be"},    {28'b0, dmem_be}, {28'b0, v.exp_be});
            if (v.st) chk({v.name, " wdata"}, dmem_wdata, v.exp_wd);
            dmem_ack   = (k == v.reqcyc - 1);
            dmem_rdata = v.rdata;
            step();
        end
        dmem_ack = 1'b0;
        chk({v.name, " resp req"},   {31'b0, dmem_req}, 32'd0);
        chk({v.name, " resp stall"}, {31'b0, stall}, 32'd0);
        chk({v.name, " resp rw"},    {31'b0, o_regwrite}, {31'b0, v.ld});
        chk({v.name, " resp mis"},   {31'b0, misaligned}, 32'd0);
        chk({v.name, " rdest"},      {27'b0, o_rdest}, idx);
        chk({v.name, " pc4"},        o_pcplus4, v.addr + 32'h1000);
        if (v.ld) chk({v.name, " mem_data"}, o_mem_data, v.exp_md);
        nop();
        step();
        chk({v.name, " idle req"}, {31'b0, dmem_req}, 32'd0);
    endtask

    initial begin
        //         name    ld  st  sz     uns  addr          sd            rdata         cyc md            be       wd
        vecs[0]  = '{"LW",   1, 0, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 1, 32'hDEADBEEF, 4'b1111, 32'h0};
        vecs[1]  = '{"LB",   1, 0, 2'b00, 0, 32'h103, 32'h0,        32'h80FFFFFF, 1, 32'hFFFFFF80, 4'b1111, 32'h0};
        vecs[2]  = '{"LBU",  1, 0, 2'b00, 1, 32'h103, 32'h0,        32'h80FFFFFF, 1, 32'h00000080, 4'b1111, 32'h0};
        vecs[3]  = '{"LH",   1, 0, 2'b01, 0, 32'h102, 32'h0,        32'h80010000, 1, 32'hFFFF8001, 4'b1111, 32'h0};
        vecs[4]  = '{"LHU",  1, 0, 2'b01, 1, 32'h100, 32'h0,        32'h1234F00F, 1, 32'h0000F00F, 4'b1111, 32'h0};
        vecs[5]  = '{"LB1",  1, 0, 2'b00, 0, 32'h101, 32'h0,        32'h0000A500, 1, 32'hFFFFFFA5, 4'b1111, 32'h0};
        vecs[6]  = '{"SB",   0, 1, 2'b00, 0, 32'h101, 32'h12345678, 32'h0,        1, 32'h0,        4'b0010, 32'h78787878};
        vecs[7]  = '{"SH",   0, 1, 2'b01, 0, 32'h102, 32'h12345678, 32'h0,        1, 32'h0,        4'b1100, 32'h56785678};
        vecs[8]  = '{"SW11", 0, 1, 2'b11, 0, 32'h108, 32'hCAFEF00D, 32'h0,        1, 32'h0,        4'b1111, 32'hCAFEF00D};
        vecs[9]  = '{"LWD3", 1, 0, 2'b10, 0, 32'h200, 32'h0,        32'h0BADF00D, 3, 32'h0BADF00D, 4'b1111, 32'h0};
        vecs[10] = '{"SB3",  0, 1, 2'b00, 0, 32'h203, 32'h000000A7, 32'h0,        2, 32'h0,        4'b1000, 32'hA7A7A7A7};

        // Reset state
        @(negedge aclk);
        chk("rst req",   {31'b0, dmem_req}, 32'd0);
        chk("rst stall", {31'b0, stall}, 32'd0);
        chk("rst rw",    {31'b0, o_regwrite}, 32'd0);
        chk("rst mis",   {31'b0, misaligned}, 32'd0);
        step();
        areset_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Delayed ack (3 REQ cycles) then an ALU op passes with no extra stall.
        drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd3, 32'h300, 32'h0);
        step();
        for (int k = 0; k < 3; k++) begin
            chk("dly stall", {31'b0, stall}, 32'd1);
            chk("dly addr", dmem_addr, 32'h300);
            dmem_ack = (k == 2);
            dmem_rdata = 32'h11223344;
            step();
        end
        dmem_ack = 1'b0;
        chk("dly md", o_mem_data, 32'h11223344);
        chk("dly rw", {31'b0, o_regwrite}, 32'd1);
        drive(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd7, 32'h55, 32'h0);
        step();
        chk("alu stall", {31'b0, stall}, 32'd0);
        chk("alu req",   {31'b0, dmem_req}, 32'd0);
        chk("alu rw",    {31'b0, o_regwrite}, 32'd1);
        chk("alu exe",   o_exe_data, 32'h55);
        chk("alu rdest", {27'b0, o_rdest}, 32'd7);

        // Back-to-back loads: RESP of the first captures the second, no dead cycle.
        drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd8, 32'h400, 32'h0);
        step();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hA1B2C3D4;
        step();
        dmem_ack = 1'b0;
        chk("b2b md1", o_mem_data, 32'hA1B2C3D4);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 5'd9, 32'h401, 32'h0);
        step();
        chk("b2b req2", {31'b0, dmem_req}, 32'd1);
        chk("b2b addr2", dmem_addr, 32'h400);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("b2b md2", o_mem_data, 32'h000000C3);
        nop();
        step();

        // Async reset mid-REQ; a late ack afterwards must be ignored.
        drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd10, 32'h500, 32'h0);
        step();
        chk("ar req before", {31'b0, dmem_req}, 32'd1);
        #1 areset_n = 1'b0;
        #1;
        chk("ar req drop", {31'b0, dmem_req}, 32'd0);
        chk("ar stall",    {31'b0, stall}, 32'd0);
        chk("ar rw",       {31'b0, o_regwrite}, 32'd0);
        nop();
        @(negedge aclk);
        areset_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h99999999;
        step();
        dmem_ack = 1'b0;
        chk("ar late req",   {31'b0, dmem_req}, 32'd0);
        chk("ar late stall", {31'b0, stall}, 32'd0);
        chk("ar late rw",    {31'b0, o_regwrite}, 32'd0);
        chk("ar late md",    o_mem_data, 32'h000000C3);

        // Misaligned word load at 0x102.
`ifdef MISALIGN_TRAP_EN
        drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd11, 32'h102, 32'h0);
        step();
        chk("mis req",   {31'b0, dmem_req}, 32'd0);
        chk("mis stall", {31'b0, stall}, 32'd0);
        chk("mis flag",  {31'b0, misaligned}, 32'd1);
        chk("mis rw",    {31'b0, o_regwrite}, 32'd0);
        nop();
        step();
        chk("mis flag clr", {31'b0, misaligned}, 32'd0);
        chk("mis idle req", {31'b0, dmem_req}, 32'd0);
`else
        run_vec('{"LWMIS", 1, 0, 2'b10, 0, 32'h102, 32'h0, 32'h87654321, 1,
                  32'h87654321, 4'b1111, 32'h0}, 11);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memaccess.md
Name: memaccess

Overview:
- Memory-access pipeline stage between execute and writeback.
- Registers execute-stage results and issues one data-memory request per load or store on a req/ack bus.
- Aligns and sign- or zero-extends load data, generates byte enables and lane-replicated store data, and stalls upstream while a request is outstanding.
- Presents ALU data, load data, PC+4, rdest, regwrite and memtoreg to writeback, which registers them on the next edge.

Parameters:
DATA_SIZE, 32, data and bus width; only 32 is supported.
ADDR_SIZE, 32, data address width.
INST_SIZE, 32, PC+4 width.
NUM_REGS, 32, register count; rdest width is $clog2(NUM_REGS).

Ports:
i_aclk  in  1  clock; all state changes on rising edge.
i_areset_n  in  1  reset, asynchronous, active-low.
i_cu_memread  in  1  instruction is a load.
i_cu_memwrite  in  1  instruction is a store; never set together with memread.
i_cu_memsize  in  2  access size: 00 byte, 01 half, 10 word; 11 treated as word.
i_cu_memunsigned  in  1  1 = zero-extend load (LBU/LHU), 0 = sign-extend.
i_cu_regwrite  in  1  pass-through register-write enable.
i_cu_memtoreg  in  2  pass-through writeback select.
i_rdest  in  $clog2(NUM_REGS)  destination register.
i_pcplus4  in  INST_SIZE  PC+4.
i_exe_data  in  DATA_SIZE  ALU result; also the byte address for loads and stores.
i_store_data  in  DATA_SIZE  rs2 value for stores.
o_stall  out  1  upstream must hold its outputs; this stage captures nothing while high.
o_dmem_req  out  1  request valid.
o_dmem_we  out  1  1 = write.
o_dmem_addr  out  ADDR_SIZE  word-aligned address: {addr[ADDR_SIZE-1:2], 2'b00}.
o_dmem_be  out  4  byte enables (writes only; 4'b1111 on reads).
o_dmem_wdata  out  DATA_SIZE  lane-replicated store data.
i_dmem_ack  in  1  request complete; read data valid in the same cycle.
i_dmem_rdata  in  DATA_SIZE  read data.
o_cu_regwrite  out  1  regwrite to writeback.
o_cu_memtoreg  out  2  stage register.
o_rdest  out  $clog2(NUM_REGS)  stage register.
o_pcplus4  out  INST_SIZE  stage register.
o_exe_data  out  DATA_SIZE  stage register.
o_mem_data  out  DATA_SIZE  extended load result.
o_misaligned  out  1  misaligned-access flag (see Optional Feature).

Behaviour:
- Capture: on each edge with o_stall=0, all i_ values load into the stage registers.
- FSM states IDLE, REQ, RESP. FSM next-state at capture: REQ if i_cu_memread|i_cu_memwrite, else IDLE.
- IDLE:
  - o_stall=0.
  - o_cu_regwrite = stage regwrite.
  - o_dmem_req=0.
- REQ:
  - o_dmem_req=1 and o_stall=1.
  - o_cu_regwrite=0, so writeback sees a bubble.
  - addr, we, be and wdata are driven from the stage registers and held stable until ack.
  - When i_dmem_ack=1: capture the aligned load result into rdata_q, then go to RESP.
  - Ack may arrive in the first REQ cycle; minimum memory-op latency is REQ + RESP = 2 cycles.
- RESP:
  - o_stall=0, o_dmem_req=0.
  - o_cu_regwrite = stage regwrite.
  - o_mem_data = rdata_q.
  - Next state is decided by the capture rule.
- Load extraction (lane = addr[1:0]):
  - byte = rdata[8*lane +: 8].
  - half = rdata[16*addr[1] +: 16].
  - word = rdata.
  - Extension to 32 bits per i_cu_memunsigned.
- Store encoding:
  - byte: wdata = {4{sd[7:0]}}, be = 4'b0001 << lane.
  - half: wdata = {2{sd[15:0]}}, be = 4'b0011 << (2*addr[1]).
  - word: wdata = sd, be = 4'b1111.
- o_mem_data outside RESP: holds the last rdata_q (don't-care to writeback).
- i_dmem_ack outside REQ: ignored.
- Reset (asynchronous, any time, including mid-REQ):
  - state=IDLE; o_dmem_req=0 immediately; o_stall=0.
  - stage regwrite, memread, memwrite = 0; o_misaligned=0.
  - Data/address stage registers and rdata_q are not reset.
  - A late ack from an aborted request is ignored.
- Back-to-back memory ops: RESP of op N captures op N+1, which enters REQ on the next cycle; no dead cycle.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - At capture, a misaligned op (half with addr[0]=1, or word with addr[1:0]!=0) goes straight to RESP with no bus request.
  - In that RESP cycle: o_misaligned=1, o_cu_regwrite=0.
  - o_misaligned is 0 in all other cycles.
- Undefined:
  - o_misaligned tied 0.
  - Low address bits are ignored per size (half uses addr[1] only, word uses lane 0), so the access is forced aligned.

Test Plan:
- LW: addr 0x100, ack in first REQ cycle, rdata 0xDEADBEEF -> o_dmem_req for 1 cycle, o_stall 1 cycle, RESP shows o_mem_data=0xDEADBEEF with o_cu_regwrite=1.
- LB / LBU: addr 0x103, rdata 0x80FF_FFFF -> LB gives 0xFFFFFF80; LBU gives 0x00000080. LH, addr 0x102, rdata 0x8001_0000 -> 0xFFFF8001.
- SB: addr 0x101, sd 0x12345678 -> we=1, be=4'b0010, wdata=0x78787878, addr=0x100. SH at 0x102 -> be=4'b1100, wdata=0x56785678.
- Ack delayed 3 cycles -> o_stall high 3 cycles, request signals stable throughout, regwrite 0 until RESP. Then ALU op immediately after passes with 0 extra stall.
- Reset asserted during REQ, then ack pulsed after release -> req drops asynchronously, state IDLE, no regwrite, ack ignored.
- MISALIGN_TRAP_EN set, LW at 0x102 -> no o_dmem_req, o_misaligned=1 for one cycle, o_cu_regwrite=0. Undefined: same op reads word 0x100.
